// File: rtl/hp_cvtsw.sv
// Signed integer to float converter: two-stage pipeline (magnitude/leading-one, then normalize/round/pack).
// Define HP_CVTSW_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module hp_cvtsw #(
  parameter int INTn = 32,
  parameter int NEXP = 8,
  parameter int NSIG = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [INTn-1:0]      in,
  output logic                 out_valid,
  output logic [NEXP+NSIG:0]   out,
  output logic                 inexact,
  output logic                 overflow
);

  localparam int PW   = $clog2(INTn);
  localparam int NW   = INTn + NSIG + 1;
  localparam int BIAS = (1 << (NEXP - 1)) - 1;
  localparam int EMAX = (1 << NEXP) - 1;

`ifdef HP_CVTSW_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  function automatic logic [PW-1:0] lead_one(input logic [INTn-1:0] m);
    lead_one = '0;
    for (int i = 0; i < INTn; i++)
      if (m[i]) lead_one = PW'(i);
  endfunction

  // Returns {carry, fraction}; a carry means the fraction wrapped to zero.
  function automatic logic [NSIG:0] round_frac(input logic [NSIG-1:0] frac,
                                               input logic guard, input logic sticky);
    round_frac = {1'b0, frac} + {{NSIG{1'b0}}, RNE & guard & (sticky | frac[0])};
  endfunction

  // Returns {overflow, packed word}; exponents at or above all-ones saturate to infinity.
  function automatic logic [NEXP+NSIG+1:0] pack(input logic sign, input logic zero,
                                                input int e, input logic [NSIG-1:0] frac);
    if (zero)
      pack = '0;
    else if (e >= EMAX)
      pack = {1'b1, sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
    else
      pack = {1'b0, sign, NEXP'(e), frac};
  endfunction

  // ---- stage 0 -> 1: sign, magnitude, leading-one position
  logic signed [INTn-1:0] in_s;
  logic                   sign_p0;
  logic [INTn-1:0]        mag_p0;

  assign in_s    = in;
  assign sign_p0 = in_s[INTn-1];
  assign mag_p0  = sign_p0 ? $unsigned(-in_s) : in;

  logic            vld_p1;
  logic            sign_p1;
  logic [INTn-1:0] mag_p1;
  logic [PW-1:0]   pos_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      sign_p1 <= sign_p0;
      mag_p1  <= mag_p0;
      pos_p1  <= lead_one(mag_p0);
    end
  end

  // ---- stage 1 -> 2: normalize, round, pack
  logic [INTn-1:0]        shl_p1;
  logic [NW-1:0]          norm_p1;
  logic [NSIG-1:0]        frac_p1;
  logic                   guard_p1;
  logic                   sticky_p1;
  logic                   zero_p1;
  logic [NSIG:0]          rnd_p1;
  int                     exp_p1;
  logic [NEXP+NSIG+1:0]   pk_p1;

  assign shl_p1    = mag_p1 << (INTn - 1 - int'(pos_p1));
  assign norm_p1   = {shl_p1, {(NSIG + 1){1'b0}}};
  assign zero_p1   = ~norm_p1[NW-1];
  assign frac_p1   = norm_p1[NW-2 -: NSIG];
  assign guard_p1  = norm_p1[INTn-1];
  assign sticky_p1 = |norm_p1[INTn-2:0];
  assign rnd_p1    = round_frac(frac_p1, guard_p1, sticky_p1);
  assign exp_p1    = BIAS + int'(pos_p1) + int'(rnd_p1[NSIG]);
  assign pk_p1     = pack(sign_p1, zero_p1, exp_p1, rnd_p1[NSIG-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      inexact   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out      <= pk_p1[NEXP+NSIG:0];
        overflow <= pk_p1[NEXP+NSIG+1];
        inexact  <= guard_p1 | sticky_p1 | pk_p1[NEXP+NSIG+1];
      end
    end
  end

endmodule

// File: tb/tb_hp_cvtsw.sv
// Scoreboard bench for hp_cvtsw at default parameters; expectations follow HP_CVTSW_RNE_EN when defined.
module tb_hp_cvtsw;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in;
  logic        out_valid;
  logic [15:0] out;
  logic        inexact;
  logic        overflow;

  hp_cvtsw dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in),
    .out_valid(out_valid), .out(out), .inexact(inexact), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] stim;
    logic [17:0] exp;   // {overflow, inexact, out}
  } item_t;

  item_t sb[$];
  int passed = 0;
  int total  = 0;

  // Reference: exact integer arithmetic on the magnitude, rounding by remainder versus half-ulp.
  function automatic logic [17:0] model(input logic [31:0] x);
    longint v, m, q, r, half;
    int p, sh, e;
    logic s, inx;
    v = longint'($signed(x));
    s = (v < 0);
    m = s ? -v : v;
    if (m == 0) return 18'd0;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    inx = 1'b0;
    if (p <= 7) begin
      q = m << (7 - p);
    end else begin
      sh   = p - 7;
      q    = m >> sh;
      r    = m - (q << sh);
      half = 64'sd1 << (sh - 1);
      inx  = (r != 0);
`ifdef HP_CVTSW_RNE_EN
      if (r > half || (r == half && q[0])) q++;
`endif
      if (q == 256) begin
        q = 128;
        p++;
      end
    end
    e = 127 + p;
    if (e >= 255) return {1'b1, 1'b1, s, 8'hFF, 7'h00};
    return {1'b0, inx, s, e[7:0], q[6:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in = '0;
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
    total++; if (out !== 16'h0) $display("FAIL reset_out: got %h want 0000", out); else passed++;
    total++; if (inexact !== 1'b0) $display("FAIL reset_inexact: got %b want 0", inexact); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_spec_vectors();
    logic [31:0] vin [10];
    logic [17:0] vexp [10];
    item_t it;
    vin = '{32'd0, 32'd128, 32'hFFFF_FFC0, 32'd16384, 32'd12345, 32'd15,
            32'h7FFF_FFFF, 32'h8000_0000, 32'h181, 32'h183};
`ifdef HP_CVTSW_RNE_EN
    vexp = '{18'h00000, 18'h04300, 18'h0C280, 18'h04680, 18'h14641, 18'h04170,
             18'h14F00, 18'h0CF00, 18'h143C0, 18'h143C2};
`else
    vexp = '{18'h00000, 18'h04300, 18'h0C280, 18'h04680, 18'h14640, 18'h04170,
             18'h14EFF, 18'h0CF00, 18'h143C0, 18'h143C1};
`endif
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      in_valid = (i < 10);
      if (i < 10) begin
        in = vin[i];
        it.due = cyc + 2; it.stim = vin[i]; it.exp = vexp[i];
        sb.push_back(it);
      end
      @(negedge clk);
      if (sb.size() != 0 && sb[0].due == cyc) begin
        it = sb.pop_front();
        total++;
        if (out_valid !== 1'b1 || {overflow, inexact, out} !== it.exp)
          $display("FAIL vec in=%h: valid=%b ovf/inx/out=%h want valid=1 %h",
                   it.stim, out_valid, {overflow, inexact, out}, it.exp);
        else passed++;
      end else begin
        total++;
        if (out_valid !== 1'b0) $display("FAIL vec_stale cyc=%0d: out_valid=%b want 0", cyc, out_valid);
        else passed++;
      end
    end
    total++;
    if (sb.size() != 0) begin
      $display("FAIL vec_timeout: %0d results outstanding want 0", sb.size());
      sb.delete();
    end else passed++;
  endtask

  task automatic test_hold_when_idle();
    logic [17:0] last;
`ifdef HP_CVTSW_RNE_EN
    last = 18'h143C2;
`else
    last = 18'h143C1;
`endif
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in = $urandom;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || {overflow, inexact, out} !== last)
        $display("FAIL hold: valid=%b ovf/inx/out=%h want valid=0 %h", out_valid, {overflow, inexact, out}, last);
      else passed++;
    end
  endtask

  task automatic test_random();
    item_t it;
    logic [31:0] v;
    for (int i = 0; i < 44; i++) begin
      @(posedge clk); #1;
      in_valid = (i < 40) && ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = 32'($urandom_range(0, 1000));
        2: v = (32'd1 << $urandom_range(0, 31)) - 32'd1;
        default: v = -(32'd1 << $urandom_range(0, 31));
      endcase
      in = v;
      if (in_valid) begin
        it.due = cyc + 2; it.stim = v; it.exp = model(v);
        sb.push_back(it);
      end
      @(negedge clk);
      if (sb.size() != 0 && sb[0].due == cyc) begin
        it = sb.pop_front();
        total++;
        if (out_valid !== 1'b1 || {overflow, inexact, out} !== it.exp)
          $display("FAIL rand in=%h: valid=%b ovf/inx/out=%h want valid=1 %h",
                   it.stim, out_valid, {overflow, inexact, out}, it.exp);
        else passed++;
      end else begin
        total++;
        if (out_valid !== 1'b0) $display("FAIL rand_stale cyc=%0d: out_valid=%b want 0", cyc, out_valid);
        else passed++;
      end
    end
    total++;
    if (sb.size() != 0) begin
      $display("FAIL rand_timeout: %0d results outstanding want 0", sb.size());
      sb.delete();
    end else passed++;
  endtask

  task automatic test_back_to_back_reset();
    logic [31:0] vals [4];
    item_t it;
    vals = '{32'd12345, 32'hFFFF_FFFF, 32'd1000, 32'hFFFF_FFF9};
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      in_valid = (i < 4) || (i == 8);
      in = (i < 4) ? vals[i] : 32'd385;
      if (in_valid) begin
        it.due = cyc + 2; it.stim = in; it.exp = model(in);
        sb.push_back(it);
      end
      @(negedge clk);
      if (sb.size() != 0 && sb[0].due == cyc) begin
        it = sb.pop_front();
        total++;
        if (out_valid !== 1'b1 || {overflow, inexact, out} !== it.exp)
          $display("FAIL b2b in=%h: valid=%b ovf/inx/out=%h want valid=1 %h",
                   it.stim, out_valid, {overflow, inexact, out}, it.exp);
        else passed++;
      end else begin
        total++;
        if (out_valid !== 1'b0) $display("FAIL b2b_stale cyc=%0d: out_valid=%b want 0", cyc, out_valid);
        else passed++;
      end
      if (i == 3) begin
        #1 rst = 1'b1; in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_rst_valid: got %b want 0", out_valid); else passed++;
        total++; if (out !== 16'h0) $display("FAIL b2b_rst_out: got %h want 0000", out); else passed++;
        total++; if (inexact !== 1'b0) $display("FAIL b2b_rst_inexact: got %b want 0", inexact); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL b2b_rst_overflow: got %b want 0", overflow); else passed++;
        sb.delete();
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_rst_hold_valid: got %b want 0", out_valid); else passed++;
        @(negedge clk) rst = 1'b0;
      end
    end
    total++;
    if (sb.size() != 0) begin
      $display("FAIL b2b_timeout: %0d results outstanding want 0", sb.size());
      sb.delete();
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_hold_when_idle();
    test_random();
    test_back_to_back_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
